// File: rtl/opcodes.sv
// Shared types and RV32I opcode match table for the multi-cycle sequencer.
`default_nettype none

package opcodes;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALTED = 3'd5,
        TRAP   = 3'd6
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ALU_R   = 4'd0,
        ALU_I   = 4'd1,
        LUI     = 4'd2,
        AUIPC   = 4'd3,
        JAL     = 4'd4,
        JALR    = 4'd5,
        BRANCH  = 4'd6,
        LOAD    = 4'd7,
        STORE   = 4'd8,
        ILLEGAL = 4'd9
    } instr_class_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC4 = 2'd2
    } wb_sel_t;

    // A word belongs to cls when (word & care) == value.
    typedef struct packed {
        logic [31:0]  care;
        logic [31:0]  value;
        instr_class_t cls;
    } opcode_mask_t;

    localparam int NUM_OPCODE_MASKS = 21;

    localparam opcode_mask_t OPCODE_MASKS [NUM_OPCODE_MASKS] = '{
        '{32'h0000_007F, 32'h0000_0037, LUI},
        '{32'h0000_007F, 32'h0000_0017, AUIPC},
        '{32'h0000_007F, 32'h0000_006F, JAL},
        '{32'h0000_707F, 32'h0000_0067, JALR},
        '{32'h0000_607F, 32'h0000_0063, BRANCH},   // BEQ/BNE
        '{32'h0000_407F, 32'h0000_4063, BRANCH},   // BLT/BGE/BLTU/BGEU
        '{32'h0000_607F, 32'h0000_0003, LOAD},     // LB/LH
        '{32'h0000_707F, 32'h0000_2003, LOAD},     // LW
        '{32'h0000_607F, 32'h0000_4003, LOAD},     // LBU/LHU
        '{32'h0000_607F, 32'h0000_0023, STORE},    // SB/SH
        '{32'h0000_707F, 32'h0000_2023, STORE},    // SW
        '{32'h0000_707F, 32'h0000_0013, ALU_I},    // ADDI
        '{32'h0000_607F, 32'h0000_2013, ALU_I},    // SLTI/SLTIU
        '{32'h0000_507F, 32'h0000_4013, ALU_I},    // XORI/ORI
        '{32'h0000_707F, 32'h0000_7013, ALU_I},    // ANDI
        '{32'hFE00_707F, 32'h0000_1013, ALU_I},    // SLLI
        '{32'hFE00_707F, 32'h0000_5013, ALU_I},    // SRLI
        '{32'hFE00_707F, 32'h4000_5013, ALU_I},    // SRAI
        '{32'hFE00_007F, 32'h0000_0033, ALU_R},    // funct7 = 0, all funct3
        '{32'hFE00_707F, 32'h4000_0033, ALU_R},    // SUB
        '{32'hFE00_707F, 32'h4000_5033, ALU_R}     // SRA
    };

    function automatic logic class_writes_rd(input instr_class_t c);
        return (c == ALU_R) || (c == ALU_I) || (c == LUI) || (c == AUIPC) ||
               (c == LOAD)  || (c == JAL)   || (c == JALR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rv32_instr_classify.sv
// Combinational RV32I instruction classifier: class, halt detect, rd != x0.
`default_nettype none

module rv32_instr_classify
    import opcodes::*;
#(
    parameter logic [31:0] HALT_WORD = 32'h0001_0073
) (
    input  logic [31:0]  instr,
    output instr_class_t instr_class,
    output logic         is_halt,
    output logic         rd_nonzero
);

    // The mask table entries are disjoint, so scan order does not matter.
    always_comb begin
        instr_class = ILLEGAL;
        for (int i = 0; i < NUM_OPCODE_MASKS; i++) begin
            if ((instr & OPCODE_MASKS[i].care) == OPCODE_MASKS[i].value) begin
                instr_class = OPCODE_MASKS[i].cls;
            end
        end
    end

    assign is_halt    = (instr == HALT_WORD);
    assign rd_nonzero = (instr[11:7] != 5'd0);

endmodule

`default_nettype wire

// File: rtl/rv32_mc_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb, owns PC and instret.
// Optional macro ILLEGAL_TRAP_EN: illegal words stop in a sticky TRAP state.
`default_nettype none

module rv32_mc_sequencer
    import opcodes::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'h0001_0073
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] instret,
    output logic        halted,
    output logic        trap
);

    localparam logic [31:0] C_PC_INIT = {RESET_PC[31:2], 2'b00};

    ctrl_state_t  r_state;
    ctrl_state_t  w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_nxt;
    logic [31:0]  r_instr;
    logic [31:0]  w_instr_nxt;
    logic [31:0]  r_instret;
    logic [31:0]  w_instret_nxt;

    instr_class_t w_class;
    logic         w_is_halt;
    logic         w_rd_nonzero;
    logic         w_imem_req;
    logic         w_dmem_req;
    logic         w_rf_we;
    logic         w_redirect;
    wb_sel_t      w_wb_sel;

    rv32_instr_classify #(
        .HALT_WORD (HALT_WORD)
    ) u_classify (
        .instr       (r_instr),
        .instr_class (w_class),
        .is_halt     (w_is_halt),
        .rd_nonzero  (w_rd_nonzero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= FETCH;
            r_pc      <= C_PC_INIT;
            r_instr   <= 32'd0;
            r_instret <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_instret <= w_instret_nxt;
        end
    end

    assign w_redirect = (w_class == JAL) || (w_class == JALR) ||
                        ((w_class == BRANCH) && branch_taken);

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_instr_nxt   = r_instr;
        w_instret_nxt = r_instret;
        w_imem_req    = 1'b0;
        w_dmem_req    = 1'b0;
        w_rf_we       = 1'b0;
        case (r_state)
            FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (w_is_halt) begin
                    w_state_nxt = HALTED;
                end else if (w_class == ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                    w_state_nxt = TRAP;
`else
                    w_state_nxt = WB;
`endif
                end else begin
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                if ((w_class == LOAD) || (w_class == STORE)) begin
                    w_state_nxt = MEM;
                end else begin
                    w_state_nxt = WB;
                end
            end
            MEM: begin
                w_dmem_req = 1'b1;
                if (dmem_ack) begin
                    w_state_nxt = WB;
                end
            end
            WB: begin
                // Illegal words reaching WB retire as NOPs: class is never a writer.
                w_rf_we       = class_writes_rd(w_class) && w_rd_nonzero;
                w_pc_nxt      = w_redirect ? (alu_result & ~32'h3) : (r_pc + 32'd4);
                w_instret_nxt = r_instret + 32'd1;
                w_state_nxt   = FETCH;
            end
            HALTED, TRAP: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_comb begin
        w_wb_sel = WB_SEL_ALU;
        if (w_class == LOAD) begin
            w_wb_sel = WB_SEL_MEM;
        end else if ((w_class == JAL) || (w_class == JALR)) begin
            w_wb_sel = WB_SEL_PC4;
        end
    end

    // Gating with reset_n lets an asserted reset kill a pending fetch at once,
    // since FETCH is also the reset state.
    assign imem_req  = w_imem_req & reset_n;
    assign imem_addr = r_pc;
    assign dmem_req  = w_dmem_req;
    assign dmem_we   = w_dmem_req && (w_class == STORE);
    assign instr     = r_instr;
    assign pc        = r_pc;
    assign rf_we     = w_rf_we;
    assign wb_sel    = w_wb_sel;
    assign instret   = r_instret;
    assign halted    = (r_state == HALTED);

`ifdef ILLEGAL_TRAP_EN
    assign trap = (r_state == TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32_mc_sequencer.sv
// Self-checking bench for rv32_mc_sequencer with directed and random instruction streams.
`default_nettype none

module tb_rv32_mc_sequencer;

    localparam logic [31:0] HALT_W = 32'h0001_0073;

    localparam int M_ALU_R = 0, M_ALU_I = 1, M_LUI = 2, M_AUIPC = 3, M_JAL = 4;
    localparam int M_JALR = 5, M_BRANCH = 6, M_LOAD = 7, M_STORE = 8, M_ILL = 9;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] instret;
    logic        halted;
    logic        trap;

    int n_total = 0;
    int n_pass  = 0;
    logic [31:0] model_pc;
    logic [31:0] model_instret;

    typedef struct {
        logic [31:0] addr;
        int          cyc;
        int          dreq;
        logic        dwe;
        int          rfwe;
        logic [1:0]  wbsel;
        logic [31:0] pc;
        logic [31:0] instret;
        logic        halted;
        logic        trap;
        bit          timeout;
    } obs_t;

    rv32_mc_sequencer #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .alu_result   (alu_result),
        .branch_taken (branch_taken),
        .instr        (instr),
        .pc           (pc),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .instret      (instret),
        .halted       (halted),
        .trap         (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode straight from the RV32I field definitions.
    function automatic int model_class(input logic [31:0] w);
        logic [6:0] op = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        case (op)
            7'h37: return M_LUI;
            7'h17: return M_AUIPC;
            7'h6F: return M_JAL;
            7'h67: return (f3 == 3'd0) ? M_JALR : M_ILL;
            7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? M_ILL : M_BRANCH;
            7'h03: return (f3 == 3'd3 || f3 >= 3'd6) ? M_ILL : M_LOAD;
            7'h23: return (f3 <= 3'd2) ? M_STORE : M_ILL;
            7'h13: begin
                if (f3 == 3'd1) return (f7 == 7'h00) ? M_ALU_I : M_ILL;
                if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? M_ALU_I : M_ILL;
                return M_ALU_I;
            end
            7'h33: begin
                if (f7 == 7'h00) return M_ALU_R;
                if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return M_ALU_R;
                return M_ILL;
            end
            default: return M_ILL;
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        imem_ack = 1'b0; dmem_ack = 1'b0; branch_taken = 1'b0; alu_result = 32'd0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_pc = 32'd0;
        model_instret = 32'd0;
    endtask

    // Drives one instruction through the DUT and records what it observed;
    // returns once the next fetch starts, or on halt/trap.
    task automatic exec_instr(input logic [31:0] word, input logic [31:0] alu, input logic bt,
                              input int fw, input int mw, output obs_t o);
        bit fetched = 1'b0;
        int reqc = 0;
        o = '{default: '0};
        alu_result = alu;
        branch_taken = bt;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if ((imem_req && fetched) || halted || trap) begin
                o.pc = pc; o.instret = instret; o.halted = halted; o.trap = trap;
                imem_ack = 1'b0; dmem_ack = 1'b0;
                return;
            end
            o.cyc++;
            if (imem_req) begin
                if (reqc == 0) o.addr = imem_addr;
                reqc++;
                if (reqc == fw + 1) begin
                    imem_ack = 1'b1; imem_rdata = word; fetched = 1'b1;
                end else begin
                    imem_ack = 1'b0; imem_rdata = $urandom;
                end
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
            if (dmem_req) begin
                o.dreq++;
                o.dwe = dmem_we;
                dmem_ack = (o.dreq == mw + 1);
            end else begin
                dmem_ack = 1'b0;
            end
            if (rf_we) begin
                o.rfwe++;
                o.wbsel = wb_sel;
            end
        end
        o.timeout = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_imem_req: got %b want 0", imem_req); else n_pass++;
        n_total++; if (dmem_req !== 1'b0) $display("FAIL reset_dmem_req: got %b want 0", dmem_req); else n_pass++;
        n_total++; if (pc !== 32'd0) $display("FAIL reset_pc: got %h want 0", pc); else n_pass++;
        n_total++; if (instret !== 32'd0) $display("FAIL reset_instret: got %h want 0", instret); else n_pass++;
        n_total++; if (instr !== 32'd0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
        n_total++; if ({halted, trap, rf_we} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {halted, trap, rf_we}); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1) $display("FAIL reset_fetch_req: got %b want 1", imem_req); else n_pass++;
        model_pc = 32'd0;
        model_instret = 32'd0;
    endtask

    task automatic test_addi();
        obs_t o;
        apply_reset();
        exec_instr(32'h0050_0093, 32'd5, 1'b0, 2, 0, o);
        n_total++; if (o.timeout) $display("FAIL addi_timeout: got timeout want completion"); else n_pass++;
        n_total++; if (o.addr !== 32'd0) $display("FAIL addi_addr: got %h want 0", o.addr); else n_pass++;
        n_total++; if (o.rfwe != 1) $display("FAIL addi_rf_we: got %0d pulses want 1", o.rfwe); else n_pass++;
        n_total++; if (o.wbsel !== 2'd0) $display("FAIL addi_wb_sel: got %0d want 0", o.wbsel); else n_pass++;
        n_total++; if (o.pc !== 32'd4) $display("FAIL addi_pc: got %h want 4", o.pc); else n_pass++;
        n_total++; if (o.instret !== 32'd1) $display("FAIL addi_instret: got %0d want 1", o.instret); else n_pass++;
        n_total++; if (o.cyc != 6) $display("FAIL addi_cpi: got %0d want 6", o.cyc); else n_pass++;
    endtask

    task automatic test_branch();
        obs_t o;
        apply_reset();
        exec_instr(32'h0000_0063, 32'h40, 1'b1, 0, 0, o);
        n_total++; if (o.pc !== 32'h40) $display("FAIL beq_taken_pc: got %h want 40", o.pc); else n_pass++;
        n_total++; if (o.rfwe != 0) $display("FAIL beq_rf_we: got %0d pulses want 0", o.rfwe); else n_pass++;
        n_total++; if (o.cyc != 4) $display("FAIL beq_cpi: got %0d want 4", o.cyc); else n_pass++;
        apply_reset();
        exec_instr(32'h0000_0063, 32'h40, 1'b0, 0, 0, o);
        n_total++; if (o.pc !== 32'h4) $display("FAIL beq_not_taken_pc: got %h want 4", o.pc); else n_pass++;
    endtask

    task automatic test_load_store();
        obs_t o;
        apply_reset();
        exec_instr(32'h0000_A283, 32'h100, 1'b0, 0, 3, o);
        n_total++; if (o.dreq != 4) $display("FAIL lw_dmem_req_cycles: got %0d want 4", o.dreq); else n_pass++;
        n_total++; if (o.dwe !== 1'b0) $display("FAIL lw_dmem_we: got %b want 0", o.dwe); else n_pass++;
        n_total++; if (o.rfwe != 1) $display("FAIL lw_rf_we: got %0d pulses want 1", o.rfwe); else n_pass++;
        n_total++; if (o.wbsel !== 2'd1) $display("FAIL lw_wb_sel: got %0d want 1", o.wbsel); else n_pass++;
        n_total++; if (o.cyc != 8) $display("FAIL lw_cpi: got %0d want 8", o.cyc); else n_pass++;
        n_total++; if (o.pc !== 32'h4) $display("FAIL lw_pc: got %h want 4", o.pc); else n_pass++;
        exec_instr(32'h0050_A023, 32'h104, 1'b0, 0, 0, o);
        n_total++; if (o.dwe !== 1'b1) $display("FAIL sw_dmem_we: got %b want 1", o.dwe); else n_pass++;
        n_total++; if (o.dreq != 1) $display("FAIL sw_dmem_req_cycles: got %0d want 1", o.dreq); else n_pass++;
        n_total++; if (o.rfwe != 0) $display("FAIL sw_rf_we: got %0d pulses want 0", o.rfwe); else n_pass++;
        n_total++; if (o.instret !== 32'd2) $display("FAIL sw_instret: got %0d want 2", o.instret); else n_pass++;
    endtask

    task automatic test_jal();
        obs_t o;
        apply_reset();
        exec_instr(32'h0000_00EF, 32'h103, 1'b0, 1, 0, o);
        n_total++; if (o.pc !== 32'h100) $display("FAIL jal_pc: got %h want 100", o.pc); else n_pass++;
        n_total++; if (o.rfwe != 1) $display("FAIL jal_rf_we: got %0d pulses want 1", o.rfwe); else n_pass++;
        n_total++; if (o.wbsel !== 2'd2) $display("FAIL jal_wb_sel: got %0d want 2", o.wbsel); else n_pass++;
        exec_instr(32'h0000_006F, 32'h203, 1'b0, 0, 0, o);
        n_total++; if (o.rfwe != 0) $display("FAIL jal_x0_rf_we: got %0d pulses want 0", o.rfwe); else n_pass++;
        n_total++; if (o.pc !== 32'h200) $display("FAIL jal_x0_pc: got %h want 200", o.pc); else n_pass++;
    endtask

    task automatic test_halt();
        obs_t o;
        int reqs = 0;
        apply_reset();
        exec_instr(32'h0050_0093, 32'd5, 1'b0, 0, 0, o);
        exec_instr(HALT_W, 32'h0, 1'b0, 0, 0, o);
        n_total++; if (o.halted !== 1'b1) $display("FAIL halt_flag: got %b want 1", o.halted); else n_pass++;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            imem_ack = 1'($urandom_range(0, 1));
            if (imem_req) reqs++;
        end
        imem_ack = 1'b0;
        n_total++; if (reqs != 0) $display("FAIL halt_no_req: got %0d requests want 0", reqs); else n_pass++;
        n_total++; if (instret !== 32'd1) $display("FAIL halt_instret: got %0d want 1", instret); else n_pass++;
        n_total++; if (pc !== 32'd4) $display("FAIL halt_pc: got %h want 4", pc); else n_pass++;
        n_total++; if (halted !== 1'b1) $display("FAIL halt_sticky: got %b want 1", halted); else n_pass++;
    endtask

    task automatic test_illegal();
        obs_t o;
        apply_reset();
        exec_instr(32'h0050_0093, 32'd5, 1'b0, 0, 0, o);
        exec_instr(32'hFFFF_FFFF, 32'h80, 1'b1, 0, 0, o);
        n_total++; if (o.timeout) $display("FAIL illegal_timeout: got timeout want completion"); else n_pass++;
        n_total++; if (o.rfwe != 0) $display("FAIL illegal_rf_we: got %0d pulses want 0", o.rfwe); else n_pass++;
`ifdef ILLEGAL_TRAP_EN
        n_total++; if (o.trap !== 1'b1) $display("FAIL illegal_trap: got %b want 1", o.trap); else n_pass++;
        n_total++; if (o.pc !== 32'd4) $display("FAIL illegal_pc_frozen: got %h want 4", o.pc); else n_pass++;
        n_total++; if (o.instret !== 32'd1) $display("FAIL illegal_instret: got %0d want 1", o.instret); else n_pass++;
        repeat (5) @(negedge clk);
        n_total++; if (imem_req !== 1'b0 || trap !== 1'b1) $display("FAIL trap_sticky: got req=%b trap=%b want req=0 trap=1", imem_req, trap); else n_pass++;
`else
        n_total++; if (o.trap !== 1'b0) $display("FAIL illegal_trap: got %b want 0", o.trap); else n_pass++;
        n_total++; if (o.pc !== 32'd8) $display("FAIL illegal_nop_pc: got %h want 8", o.pc); else n_pass++;
        n_total++; if (o.instret !== 32'd2) $display("FAIL illegal_instret: got %0d want 2", o.instret); else n_pass++;
        n_total++; if (o.cyc != 3) $display("FAIL illegal_cpi: got %0d want 3", o.cyc); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_mem();
        bit seen = 1'b0;
        apply_reset();
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            imem_ack = imem_req;
            imem_rdata = 32'h0000_A283;
            dmem_ack = 1'b0;
            if (dmem_req) seen = 1'b1;
        end
        imem_ack = 1'b0;
        n_total++; if (!seen) $display("FAIL mid_mem_reach: got no dmem_req want dmem_req"); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (dmem_req !== 1'b0 || imem_req !== 1'b0) $display("FAIL mid_mem_reset: got dmem_req=%b imem_req=%b want 0 0", dmem_req, imem_req); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        model_pc = 32'd0;
        model_instret = 32'd0;
    endtask

    task automatic test_pc_wrap();
        obs_t o;
        apply_reset();
        exec_instr(32'h0000_006F, 32'hFFFF_FFFF, 1'b0, 0, 0, o);
        n_total++; if (o.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup_pc: got %h want fffffffc", o.pc); else n_pass++;
        exec_instr(32'h0050_0093, 32'd5, 1'b0, 0, 0, o);
        n_total++; if (o.pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", o.pc); else n_pass++;
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] w;
        logic [31:0] alu;
        logic [31:0] exp_pc;
        logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic bt;
        int cls, fw, mw, exp_cyc, exp_dreq;
        bit exp_rf, is_mem;
        logic [1:0] exp_wb;
        apply_reset();
        for (int n = 0; n < 60; n++) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0) w[6:0] = ops[$urandom_range(0, 8)];
            cls = model_class(w);
`ifdef ILLEGAL_TRAP_EN
            if (cls == M_ILL) begin w = 32'h0000_0013; cls = M_ALU_I; end
`endif
            if (w == HALT_W) begin w = 32'h0000_0013; cls = M_ALU_I; end
            alu = $urandom;
            bt = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            is_mem = (cls == M_LOAD) || (cls == M_STORE);
            exp_rf = (cls == M_ALU_R || cls == M_ALU_I || cls == M_LUI || cls == M_AUIPC ||
                      cls == M_LOAD || cls == M_JAL || cls == M_JALR) && (w[11:7] != 5'd0);
            exp_wb = (cls == M_LOAD) ? 2'd1 : (cls == M_JAL || cls == M_JALR) ? 2'd2 : 2'd0;
            exp_pc = (cls == M_JAL || cls == M_JALR || (cls == M_BRANCH && bt)) ?
                     {alu[31:2], 2'b00} : model_pc + 32'd4;
            exp_cyc = (cls == M_ILL) ? 3 + fw : is_mem ? 5 + fw + mw : 4 + fw;
            exp_dreq = is_mem ? mw + 1 : 0;
            exec_instr(w, alu, bt, fw, mw, o);
            n_total++; if (o.timeout) $display("FAIL rand_timeout: word %h got timeout want completion", w); else n_pass++;
            n_total++; if (o.addr !== model_pc) $display("FAIL rand_addr: word %h got %h want %h", w, o.addr, model_pc); else n_pass++;
            n_total++; if (o.cyc != exp_cyc) $display("FAIL rand_cpi: word %h got %0d want %0d", w, o.cyc, exp_cyc); else n_pass++;
            n_total++; if (o.dreq != exp_dreq) $display("FAIL rand_dmem_req: word %h got %0d want %0d", w, o.dreq, exp_dreq); else n_pass++;
            if (is_mem) begin
                n_total++; if (o.dwe !== (cls == M_STORE)) $display("FAIL rand_dmem_we: word %h got %b want %b", w, o.dwe, cls == M_STORE); else n_pass++;
            end
            n_total++; if (o.rfwe != int'(exp_rf)) $display("FAIL rand_rf_we: word %h got %0d want %0d", w, o.rfwe, exp_rf); else n_pass++;
            if (exp_rf) begin
                n_total++; if (o.wbsel !== exp_wb) $display("FAIL rand_wb_sel: word %h got %0d want %0d", w, o.wbsel, exp_wb); else n_pass++;
            end
            n_total++; if (o.pc !== exp_pc) $display("FAIL rand_pc: word %h got %h want %h", w, o.pc, exp_pc); else n_pass++;
            n_total++; if (o.instret !== model_instret + 32'd1) $display("FAIL rand_instret: word %h got %0d want %0d", w, o.instret, model_instret + 32'd1); else n_pass++;
            model_pc = exp_pc;
            model_instret = model_instret + 32'd1;
        end
    endtask

    initial begin
        reset_n = 1'b1;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        dmem_ack = 1'b0;
        alu_result = 32'd0;
        branch_taken = 1'b0;
        model_pc = 32'd0;
        model_instret = 32'd0;
        test_reset();
        test_addi();
        test_branch();
        test_load_store();
        test_jal();
        test_halt();
        test_illegal();
        test_reset_mid_mem();
        test_pc_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
